// File: rtl/bpt_scan_pipe_pkg.sv
// Shared types and helpers for the bit-partition translator scan pipe.
// Holds the FSM state encoding and the leading-one locator used on word capture.
package bpt_scan_pipe_pkg;

  typedef enum logic [0:0] {
    BPT_IDLE = 1'b0,
    BPT_SCAN = 1'b1
  } bpt_state_e;

  // Widest search word the leading-one helper supports.
  localparam int unsigned BPT_MAX_W = 64;

  function automatic int bpt_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot position of the most significant set bit among the low 'width' bits;
  // bit 'width' is set when none of them is set.
  function automatic logic [BPT_MAX_W:0] lead_one_idx(input logic [BPT_MAX_W-1:0] word,
                                                      input int                   width);
    logic [BPT_MAX_W:0] oh;
    oh = '0;
    oh[7'(width)] = 1'b1;
    for (int i = 0; i < BPT_MAX_W; i++) begin
      if ((i < width) && word[6'(i)]) begin
        oh = '0;
        oh[7'(i)] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/bpt_scan_pipe_if.sv
// Search-word input and partition-beat output bundle of bpt_scan_pipe.
// slave is the block's view, master the view of whatever drives and drains it.
interface bpt_scan_pipe_if #(
  parameter int W  = 16,
  parameter int B  = 8,
  parameter int NL = 1
);
  localparam int P   = W / B;
  localparam int PBW = (P > 1) ? $clog2(P) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           in_sword;
  logic                   out_valid;
  logic                   out_ready;
  logic [NL*B-1:0]        BPI;
  logic [NL*(2**B)-1:0]   data;
  logic [PBW-1:0]         part_base;
  logic                   last;
  logic [W:0]             LI;
  logic                   in_sw_pre;

  modport slave (
    input  in_valid, in_sword, out_ready,
    output in_ready, out_valid, BPI, data, part_base, last, LI, in_sw_pre
  );

  modport master (
    output in_valid, in_sword, out_ready,
    input  in_ready, out_valid, BPI, data, part_base, last, LI, in_sw_pre
  );

endinterface

// File: rtl/bpt_scan_pipe_decode.sv
// Partition value to one-hot SRAM row select decoder (combinational).
module bpt_scan_pipe_decode #(
  parameter int B = 8
) (
  input  logic [B-1:0]      val_i,
  output logic [2**B-1:0]   onehot_o
);

  always_comb begin
    onehot_o         = '0;
    onehot_o[val_i]  = 1'b1;
  end

endmodule

// File: rtl/bpt_scan_pipe.sv
// Bit-partition translator: captures a W-bit search word and emits its B-bit partitions NL per beat.
// Optional macro BPT_PRE_DETECT_EN enables the repeat-search flag (in_sw_pre); otherwise it is tied 0.
module bpt_scan_pipe
  import bpt_scan_pipe_pkg::*;
#(
  parameter int W  = 16,
  parameter int B  = 8,
  parameter int NL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bpt_scan_pipe_if.slave  bus
);

  localparam int P      = W / B;
  localparam int NBEAT  = P / NL;
  localparam int BW     = bpt_clog2_min1(NBEAT);
  localparam int PBW    = bpt_clog2_min1(P);
  localparam int LANE_W = NL * B;
  localparam int ROWS   = 2 ** B;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  generate
    if (W % B != 0) begin : g_bad_w
      $error("bpt_scan_pipe: W must be a multiple of B");
    end
    if (P % NL != 0) begin : g_bad_nl
      $error("bpt_scan_pipe: partition count must be a multiple of NL");
    end
    if (W > BPT_MAX_W) begin : g_bad_max
      $error("bpt_scan_pipe: W exceeds BPT_MAX_W");
    end
  endgenerate

  bpt_state_e       state_q;
  logic [BW-1:0]    beat_q;
  logic [W-1:0]     word_q;
  logic [W:0]       li_q;
  logic             pre_q;
  logic             live_q;

  logic             scan;
  logic             last_beat;
  logic             accept;
  logic [W:0]       li_d;
  logic             pre_d;
  logic [LANE_W-1:0] beat_words [NBEAT];
  logic [LANE_W-1:0] lanes;
  logic [ROWS-1:0]  row_oh [NL];

  assign scan      = (state_q == BPT_SCAN);
  assign last_beat = scan && (beat_q == LAST_BEAT);

  // live_q keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = live_q && (!scan || (last_beat && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  assign li_d = (W+1)'(lead_one_idx(BPT_MAX_W'(bus.in_sword), W));

`ifdef BPT_PRE_DETECT_EN
  logic [W-1:0] prev_q;
  logic         prev_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (accept) begin
      prev_q     <= bus.in_sword;
      prev_vld_q <= 1'b1;
    end
  end

  assign pre_d = prev_vld_q && (bus.in_sword == prev_q);
`else
  assign pre_d = 1'b0;
`endif

  // Group the word into beat-sized slices so the beat counter selects a whole beat at once.
  genvar gi;
  generate
    for (gi = 0; gi < NBEAT; gi++) begin : g_beat
      assign beat_words[gi] = word_q[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign lanes = beat_words[beat_q];

  generate
    for (gi = 0; gi < NL; gi++) begin : g_lane
      bpt_scan_pipe_decode #(.B(B)) u_dec (
        .val_i    (lanes[gi*B +: B]),
        .onehot_o (row_oh[gi])
      );
      // Row select is only driven while a beat is on offer, so reset and idle show zero.
      assign bus.data[gi*ROWS +: ROWS] = scan ? row_oh[gi] : '0;
    end
  endgenerate

  assign bus.out_valid = scan;
  assign bus.BPI       = lanes;
  assign bus.part_base = PBW'(int'(beat_q) * NL);
  assign bus.last      = last_beat;
  assign bus.LI        = li_q;
  assign bus.in_sw_pre = pre_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BPT_IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      li_q    <= '0;
      pre_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        state_q <= BPT_SCAN;
        beat_q  <= '0;
        word_q  <= bus.in_sword;
        li_q    <= li_d;
        pre_q   <= pre_d;
      end else if (scan && bus.out_ready) begin
        if (last_beat) begin
          state_q <= BPT_IDLE;
          beat_q  <= '0;
        end else begin
          beat_q <= beat_q + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bpt_scan_pipe.sv
// Self-checking bench for bpt_scan_pipe: directed table, corner sequences and random traffic vs a reference model.
module tb_bpt_scan_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bpt_scan_pipe_if #(.W(16), .B(8), .NL(1)) bus1 ();
  bpt_scan_pipe_if #(.W(16), .B(8), .NL(2)) bus2 ();

  bpt_scan_pipe #(.W(16), .B(8), .NL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  bpt_scan_pipe #(.W(16), .B(8), .NL(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int errors = 0;
  int checks = 0;

`ifdef BPT_PRE_DETECT_EN
  localparam bit PRE_ON = 1'b1;
`else
  localparam bit PRE_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Leading-one reference: position = floor(log2(w)), or bit 16 for a zero word.
  function automatic logic [16:0] ref_li(input logic [15:0] w);
    int k;
    if (w == 16'h0) return 17'h10000;
    k = $clog2(int'(w) + 1) - 1;
    return 17'(1) << k;
  endfunction

  // ---------------- reference model / monitor for the NL=1 instance ----------------
  typedef struct {
    logic [7:0]  bpi;
    logic        pb;
    logic        last;
    logic [16:0] li;
    logic        pre;
  } beat_t;

  beat_t        expq[$];
  logic [15:0]  m_prev;
  bit           m_prev_v;
  bit           hold_v;
  logic [511:0] hold_snap;

  function automatic logic [511:0] snap1();
    return 512'({bus1.out_valid, bus1.BPI, bus1.part_base, bus1.last, bus1.LI, bus1.in_sw_pre, bus1.data});
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expq.delete();
      m_prev_v = 1'b0;
      hold_v   = 1'b0;
    end else begin
      if (hold_v) check("hold_stable", snap1(), hold_snap);
      if (bus1.out_valid && bus1.out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_beat", 512'(bus1.BPI), 512'(0));
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got beat bpi=%0h required none", bus1.BPI);
        end else begin
          beat_t e;
          logic [511:0] ed;
          e  = expq.pop_front();
          ed = '0;
          ed[e.bpi] = 1'b1;
          $display("beat bpi=%02h pb=%0d last=%0d li=%05h pre=%0d", bus1.BPI, bus1.part_base,
                   bus1.last, bus1.LI, bus1.in_sw_pre);
          check("model_beat",
                512'({bus1.BPI, bus1.part_base, bus1.last, bus1.LI, bus1.in_sw_pre, bus1.data}),
                512'({e.bpi, e.pb, e.last, e.li, e.pre, ed[255:0]}));
        end
      end
      hold_v    = bus1.out_valid && !bus1.out_ready;
      hold_snap = snap1();
      if (bus1.in_valid && bus1.in_ready) begin
        logic [15:0] w;
        w = bus1.in_sword;
        for (int k = 0; k < 2; k++) begin
          beat_t b;
          b.bpi  = 8'((w >> (8 * k)) & 16'h00ff);
          b.pb   = (k == 1);
          b.last = (k == 1);
          b.li   = ref_li(w);
          b.pre  = PRE_ON && m_prev_v && (w == m_prev);
          expq.push_back(b);
        end
        m_prev   = w;
        m_prev_v = 1'b1;
      end
    end
  end

  // ---------------- driver helpers (inputs change at posedge+1) ----------------
  task automatic send_word(input logic [15:0] w);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    bus1.in_valid = 1'b1;
    bus1.in_sword = w;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = bus1.in_ready;
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready for %04h required acceptance", w);
    end
  endtask

  task automatic get_beat(input int bound, output logic [7:0] bpi, output logic pb,
                          output logic last, output logic [16:0] li, output logic pre,
                          output logic [255:0] dat);
    bit got;
    got = 1'b0;
    bpi = 'x; pb = 'x; last = 'x; li = 'x; pre = 'x; dat = 'x;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge clk);
      if (bus1.out_valid && bus1.out_ready) begin
        got  = 1'b1;
        bpi  = bus1.BPI;
        pb   = bus1.part_base;
        last = bus1.last;
        li   = bus1.LI;
        pre  = bus1.in_sw_pre;
        dat  = bus1.data;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got no beat within %0d cycles required one", bound);
    end
  endtask

  typedef struct {
    logic [15:0] w;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [16:0] li;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0]   bpi;
    logic         pb, last, pre;
    logic [16:0]  li;
    logic [255:0] dat, ed;
    logic [7:0]   seen[6];
    logic [7:0]   b2b_exp[6];
    logic [15:0]  b2b_w[3];
    logic [15:0]  pre_w[3];
    logic         pre_exp[3];
    logic [511:0] ed2;
    int           n, idx;
    bit           bubble, acc;

    tbl[0] = '{16'h0010, 8'h10, 8'h00, 17'h00010};
    tbl[1] = '{16'h008a, 8'h8a, 8'h00, 17'h00080};
    tbl[2] = '{16'h00fb, 8'hfb, 8'h00, 17'h00080};
    tbl[3] = '{16'h00f1, 8'hf1, 8'h00, 17'h00080};
    tbl[4] = '{16'h0000, 8'h00, 8'h00, 17'h10000};
    tbl[5] = '{16'h1234, 8'h34, 8'h12, 17'h01000};

    bus1.in_valid = 0; bus1.in_sword = '0; bus1.out_ready = 0;
    bus2.in_valid = 0; bus2.in_sword = '0; bus2.out_ready = 0;

    // reset state
    #12;
    check("reset_outs1", 512'({bus1.out_valid, bus1.in_ready, bus1.BPI, bus1.data, bus1.part_base,
                               bus1.last, bus1.LI, bus1.in_sw_pre}), 512'(0));
    check("reset_outs2", 512'({bus2.out_valid, bus2.in_ready, bus2.BPI, bus2.data, bus2.part_base,
                               bus2.last, bus2.LI, bus2.in_sw_pre}), 512'(0));
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 512'(bus1.in_ready), 512'(1));

    // directed table, one word at a time
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].w);
      get_beat(1, bpi, pb, last, li, pre, dat);
      ed = '0; ed[tbl[i].e0] = 1'b1;
      $display("tbl word=%04h beat0 bpi=%02h", tbl[i].w, bpi);
      check("tbl_beat0", 512'({bpi, pb, last, li, dat}), 512'({tbl[i].e0, 1'b0, 1'b0, tbl[i].li, ed}));
      get_beat(1, bpi, pb, last, li, pre, dat);
      ed = '0; ed[tbl[i].e1] = 1'b1;
      $display("tbl word=%04h beat1 bpi=%02h", tbl[i].w, bpi);
      check("tbl_beat1", 512'({bpi, pb, last, li, dat}), 512'({tbl[i].e1, 1'b1, 1'b1, tbl[i].li, ed}));
    end

    // back-to-back words with in_valid held high
    b2b_w   = '{16'h008a, 16'h00fb, 16'h00f1};
    b2b_exp = '{8'h8a, 8'h00, 8'hfb, 8'h00, 8'hf1, 8'h00};
    n = 0; idx = 0; bubble = 1'b0;
    @(posedge clk); #1;
    bus1.in_valid = 1'b1;
    bus1.in_sword = b2b_w[0];
    for (int c = 0; c < 20 && n < 6; c++) begin
      @(negedge clk);
      if (bus1.out_valid && bus1.out_ready) begin
        seen[n] = bus1.BPI;
        check("b2b_li", 512'(bus1.LI), 512'(17'h00080));
        n++;
      end else if (n > 0) begin
        bubble = 1'b1;
      end
      acc = bus1.in_valid && bus1.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx >= 3) bus1.in_valid = 1'b0;
        else          bus1.in_sword = b2b_w[idx];
      end
    end
    bus1.in_valid = 1'b0;
    check("b2b_count", 512'(n), 512'(6));
    check("b2b_no_bubble", 512'(bubble), 512'(0));
    for (int i = 0; i < n; i++) begin
      $display("b2b beat %0d bpi=%02h", i, seen[i]);
      check("b2b_bpi", 512'(seen[i]), 512'(b2b_exp[i]));
    end

    // backpressure on beat0 of 0x1234
    bus1.out_ready = 1'b0;
    send_word(16'h1234);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_hold", 512'({bus1.out_valid, bus1.BPI, bus1.in_ready, bus1.last}),
            512'({1'b1, 8'h34, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    bus1.out_ready = 1'b1;
    get_beat(1, bpi, pb, last, li, pre, dat);
    check("stall_beat0", 512'({bpi, last}), 512'({8'h34, 1'b0}));
    get_beat(1, bpi, pb, last, li, pre, dat);
    check("stall_beat1", 512'({bpi, last}), 512'({8'h12, 1'b1}));

    // reset asserted mid-scan of 0xabcd
    send_word(16'habcd);
    get_beat(1, bpi, pb, last, li, pre, dat);
    check("rst_beat0", 512'(bpi), 512'(8'hcd));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", 512'({bus1.out_valid, bus1.in_ready, bus1.data, bus1.LI, bus1.last}), 512'(0));
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 512'(bus1.in_ready), 512'(1));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_stale", 512'(bus1.out_valid), 512'(0));
    end

    // repeat-search flag, first word after reset
    pre_w   = '{16'h00f1, 16'h00f1, 16'h00f2};
    pre_exp = '{1'b0, PRE_ON, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_word(pre_w[i]);
      get_beat(1, bpi, pb, last, li, pre, dat);
      $display("pre word=%04h pre=%0d", pre_w[i], pre);
      check("pre_beat0", 512'(pre), 512'(pre_exp[i]));
      get_beat(1, bpi, pb, last, li, pre, dat);
      check("pre_beat1", 512'(pre), 512'(pre_exp[i]));
    end

    // NL=2 instance: single-beat mode
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus2.in_valid = 1'b1;
      bus2.in_sword = pre_w[i];
      @(negedge clk);
      check("nl2_ready", 512'(bus2.in_ready), 512'(1));
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      ed2 = '0;
      ed2[pre_w[i][7:0]] = 1'b1;
      ed2[256 + int'(pre_w[i][15:8])] = 1'b1;
      $display("nl2 word=%04h bpi=%04h last=%0d pre=%0d", pre_w[i], bus2.BPI, bus2.last, bus2.in_sw_pre);
      check("nl2_beat", 512'({bus2.out_valid, bus2.BPI, bus2.part_base, bus2.last, bus2.LI, bus2.in_sw_pre}),
            512'({1'b1, pre_w[i], 1'b0, 1'b1, 17'h00080, pre_exp[i]}));
      check("nl2_data", 512'(bus2.data), ed2);
    end

    // random traffic checked by the monitor's model
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus1.in_valid && ($urandom_range(0, 1) == 1)) begin
        case ($urandom_range(0, 3))
          0:       bus1.in_sword = bus1.in_sword;
          1:       bus1.in_sword = 16'h0000;
          2:       bus1.in_sword = 16'(1) << $urandom_range(0, 15);
          default: bus1.in_sword = 16'($urandom);
        endcase
        bus1.in_valid = 1'b1;
      end
      @(negedge clk);
      acc = bus1.in_valid && bus1.in_ready;
      @(posedge clk); #1;
      if (acc) bus1.in_valid = 1'b0;
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    for (int c = 0; c < 10 && expq.size() != 0; c++) @(negedge clk);
    check("drain_empty", 512'(expq.size()), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
